collision_engine: RTL and testbench

- Parametrised successor to the single-pipe kill detector for the flappy-bird game.
- Once per frame it scans NUM_PIPES pipe channels sequentially, one pipe per clock, against a snapshot of the bird's y position.
- It tracks a lives counter with post-hit invulnerability frames and produces a sticky killed flag for the game-state FSM.
- It sits between the pipe/bird motion logic and the game controller; all evaluation is in the Clk domain.

---
 rtl/collision_engine.sv | 182 ++++++++++++++++++
 tb/tb_collision_engine.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/collision_engine.sv
// Multi-pipe collision and lives tracker: scans one pipe channel per clock each frame.
// Optional CEILING_KILL_EN macro makes a bird touching the ceiling an immediate crash.
module collision_engine #(
    parameter int NUM_PIPES     = 3,
    parameter int W             = 10,
    parameter int BIRD_R        = 12,
    parameter int GAP_HALF      = 40,
    parameter int XMIN          = 265,
    parameter int XMAX          = 375,
    parameter int FLOOR_Y       = 470,
    parameter int START_LIVES   = 3,
    parameter int INVULN_FRAMES = 30
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_tick,
    input  logic                   restart,
    input  logic [W-1:0]           birdy,
    input  logic [NUM_PIPES*W-1:0] pipex,
    input  logic [NUM_PIPES*W-1:0] pipey,
    output logic                   busy,
    output logic                   hit_pulse,
    output logic [2:0]             hit_idx,
    output logic [3:0]             lives,
    output logic                   invuln,
    output logic                   killed
);

    typedef enum logic [1:0] {IDLE, SCAN, RESOLVE, DEAD} state_t;

    localparam int IDXW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int IVW  = ($clog2(INVULN_FRAMES + 1) > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    localparam logic [W-1:0]    XMIN_C    = W'(XMIN);
    localparam logic [W-1:0]    XMAX_C    = W'(XMAX);
    localparam logic [W-1:0]    FLOOR_C   = W'(FLOOR_Y);
    localparam logic [W:0]      BIRD_C    = (W+1)'(BIRD_R);
    localparam logic [W:0]      GAP_C     = (W+1)'(GAP_HALF);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_PIPES - 1);
    localparam logic [3:0]      LIVES_C   = 4'(START_LIVES);
    localparam logic [IVW-1:0]  INVULN_C  = IVW'(INVULN_FRAMES);

    state_t          state_q, state_d;
    logic [W-1:0]    by_q, by_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            hit_acc_q, hit_acc_d;
    logic            floor_acc_q, floor_acc_d;
    logic [2:0]      first_idx_q, first_idx_d;
    logic [3:0]      lives_q, lives_d;
    logic            killed_q, killed_d;
    logic            hit_pulse_q, hit_pulse_d;
    logic [2:0]      hit_idx_q, hit_idx_d;
    logic [IVW-1:0]  inv_q, inv_d;

    logic [W-1:0] cur_x, cur_y;
    logic [W:0]   bird_bot, gap_bot, bird_top, gap_top;
    logic         active, bot_hit, top_hit, pipe_hit, crash;

    always_comb begin
        cur_x = '0;
        cur_y = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_x = pipex[i*W +: W];
                cur_y = pipey[i*W +: W];
            end
        end
    end

    // Geometry is done one bit wider so the +radius sums cannot wrap.
    always_comb begin
        bird_bot = {1'b0, by_q} + BIRD_C;
        gap_bot  = {1'b0, cur_y} + GAP_C;
        bird_top = ({1'b0, by_q}  >= BIRD_C) ? ({1'b0, by_q}  - BIRD_C) : '0;
        gap_top  = ({1'b0, cur_y} >= GAP_C)  ? ({1'b0, cur_y} - GAP_C)  : '0;
        active   = (cur_x >= XMIN_C) && (cur_x <= XMAX_C);
        bot_hit  = bird_bot >= gap_bot;
        top_hit  = bird_top <= gap_top;
        pipe_hit = active && (bot_hit || top_hit);
`ifdef CEILING_KILL_EN
        crash    = (by_q >= FLOOR_C) || ({1'b0, by_q} <= BIRD_C);
`else
        crash    = (by_q >= FLOOR_C);
`endif
    end

    always_comb begin
        state_d     = state_q;
        by_d        = by_q;
        idx_d       = idx_q;
        hit_acc_d   = hit_acc_q;
        floor_acc_d = floor_acc_q;
        first_idx_d = first_idx_q;
        lives_d     = lives_q;
        killed_d    = killed_q;
        hit_pulse_d = 1'b0;
        hit_idx_d   = hit_idx_q;
        inv_d       = inv_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    by_d        = birdy;
                    hit_acc_d   = 1'b0;
                    floor_acc_d = 1'b0;
                    first_idx_d = '0;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (pipe_hit) begin
                    hit_acc_d = 1'b1;
                    if (!hit_acc_q) first_idx_d = 3'(idx_q);
                end
                if (idx_q == '0 && crash) floor_acc_d = 1'b1;
                if (idx_q == LAST_IDX) state_d = RESOLVE;
                else                   idx_d   = idx_q + 1'b1;
            end
            RESOLVE: begin
                // Crashes are fatal regardless of invulnerability.
                if (floor_acc_q) begin
                    lives_d     = '0;
                    killed_d    = 1'b1;
                    hit_pulse_d = 1'b1;
                    state_d     = DEAD;
                end else if (hit_acc_q && inv_q == '0) begin
                    hit_pulse_d = 1'b1;
                    hit_idx_d   = first_idx_q;
                    lives_d     = (lives_q != '0) ? lives_q - 1'b1 : '0;
                    if (lives_q <= 4'd1) begin
                        killed_d = 1'b1;
                        state_d  = DEAD;
                    end else begin
                        inv_d   = INVULN_C;
                        state_d = IDLE;
                    end
                end else begin
                    if (inv_q != '0) inv_d = inv_q - 1'b1;
                    state_d = IDLE;
                end
            end
            DEAD: state_d = DEAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset || restart) begin
            state_q     <= IDLE;
            by_q        <= '0;
            idx_q       <= '0;
            hit_acc_q   <= 1'b0;
            floor_acc_q <= 1'b0;
            first_idx_q <= '0;
            lives_q     <= LIVES_C;
            killed_q    <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_idx_q   <= '0;
            inv_q       <= '0;
        end else begin
            state_q     <= state_d;
            by_q        <= by_d;
            idx_q       <= idx_d;
            hit_acc_q   <= hit_acc_d;
            floor_acc_q <= floor_acc_d;
            first_idx_q <= first_idx_d;
            lives_q     <= lives_d;
            killed_q    <= killed_d;
            hit_pulse_q <= hit_pulse_d;
            hit_idx_q   <= hit_idx_d;
            inv_q       <= inv_d;
        end
    end

    assign busy      = (state_q == SCAN) || (state_q == RESOLVE);
    assign hit_pulse = hit_pulse_q;
    assign hit_idx   = hit_idx_q;
    assign lives     = lives_q;
    assign invuln    = (inv_q != '0);
    assign killed    = killed_q;

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine with default parameters (3 pipes, 10-bit coords).
module tb_collision_engine;

    localparam int W = 10;
    localparam logic [9:0] OFF = 10'd100;

    logic        Clk = 1'b0;
    logic        Reset, frame_tick, restart;
    logic [9:0]  birdy;
    logic [29:0] pipex, pipey;
    logic        busy, hit_pulse, invuln, killed;
    logic [2:0]  hit_idx;
    logic [3:0]  lives;

    int n_asserts = 0;
    int n_fail    = 0;

    collision_engine dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .restart    (restart),
        .birdy      (birdy),
        .pipex      (pipex),
        .pipey      (pipey),
        .busy       (busy),
        .hit_pulse  (hit_pulse),
        .hit_idx    (hit_idx),
        .lives      (lives),
        .invuln     (invuln),
        .killed     (killed)
    );

    always #5 Clk = ~Clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; returns one step after the resolve edge.
    task automatic apply_stimulus(input logic [9:0] by, input logic [29:0] px, input logic [29:0] py);
        birdy      = by;
        pipex      = px;
        pipey      = py;
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        check_output("busy_rise", busy, 1);
        repeat (3) @(posedge Clk);
        #1;
        check_output("busy_hold", busy, 1);
        check_output("pulse_early", hit_pulse, 0);
        @(posedge Clk); #1;
        check_output("busy_fall", busy, 0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge Clk); #1;
        restart = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; restart = 1'b0; frame_tick = 1'b0;
        birdy = '0; pipex = {OFF, OFF, OFF}; pipey = {10'd240, 10'd240, 10'd240};
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        check_output("rst_lives", lives, 3);
        check_output("rst_killed", killed, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_pulse", hit_pulse, 0);
        check_output("rst_hit_idx", hit_idx, 0);
        check_output("rst_invuln", invuln, 0);

        // No active pipes
        apply_stimulus(10'd240, {OFF, OFF, OFF}, {10'd240, 10'd240, 10'd240});
        check_output("clear_pulse", hit_pulse, 0);
        check_output("clear_lives", lives, 3);
        check_output("clear_killed", killed, 0);

        // Pipe 1 bottom hit: 240+12=252 >= 200+40=240
        apply_stimulus(10'd240, {OFF, 10'd300, OFF}, {10'd240, 10'd200, 10'd240});
        check_output("hit1_pulse", hit_pulse, 1);
        check_output("hit1_idx", hit_idx, 1);
        check_output("hit1_lives", lives, 2);
        check_output("hit1_invuln", invuln, 1);
        @(posedge Clk); #1;
        check_output("hit1_pulse_drop", hit_pulse, 0);

        // Same hit for 30 frames while invulnerable
        for (int k = 1; k <= 30; k++) begin
            apply_stimulus(10'd240, {OFF, 10'd300, OFF}, {10'd240, 10'd200, 10'd240});
            check_output("inv_pulse", hit_pulse, 0);
            check_output("inv_lives", lives, 2);
            check_output("inv_flag", invuln, (k < 30) ? 1 : 0);
        end

        apply_stimulus(10'd240, {OFF, 10'd300, OFF}, {10'd240, 10'd200, 10'd240});
        check_output("hit2_pulse", hit_pulse, 1);
        check_output("hit2_lives", lives, 1);
        check_output("hit2_invuln", invuln, 1);

        pulse_restart();
        check_output("rs1_lives", lives, 3);
        check_output("rs1_invuln", invuln, 0);

        // Just outside the active x window
        apply_stimulus(10'd240, {10'd376, OFF, 10'd264}, {10'd200, 10'd240, 10'd200});
        check_output("xedge_out_pulse", hit_pulse, 0);
        check_output("xedge_out_lives", lives, 3);

        // Pipes 0 and 2 at the inclusive edges, both colliding
        apply_stimulus(10'd240, {10'd375, OFF, 10'd265}, {10'd200, 10'd240, 10'd200});
        check_output("multi_pulse", hit_pulse, 1);
        check_output("multi_idx", hit_idx, 0);
        check_output("multi_lives", lives, 2);
        @(posedge Clk); #1;
        check_output("multi_pulse_drop", hit_pulse, 0);
        check_output("multi_lives_hold", lives, 2);

        // Floor crash while invulnerable
        apply_stimulus(10'd475, {OFF, OFF, OFF}, {10'd240, 10'd240, 10'd240});
        check_output("floor_pulse", hit_pulse, 1);
        check_output("floor_lives", lives, 0);
        check_output("floor_killed", killed, 1);
        check_output("floor_idx", hit_idx, 0);

        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        check_output("dead_busy", busy, 0);
        repeat (4) @(posedge Clk);
        #1;
        check_output("dead_lives", lives, 0);
        check_output("dead_killed", killed, 1);
        check_output("dead_pulse", hit_pulse, 0);

        pulse_restart();
        check_output("rs2_lives", lives, 3);
        check_output("rs2_killed", killed, 0);
        check_output("rs2_busy", busy, 0);

        // Gap top saturates to 0: birdy=13 clears, birdy=12 touches
        apply_stimulus(10'd13, {10'd300, OFF, OFF}, {10'd20, 10'd240, 10'd240});
        check_output("top13_pulse", hit_pulse, 0);
        check_output("top13_lives", lives, 3);
        apply_stimulus(10'd12, {10'd300, OFF, OFF}, {10'd20, 10'd240, 10'd240});
        check_output("top12_pulse", hit_pulse, 1);
        check_output("top12_idx", hit_idx, 2);
        check_output("top12_lives", lives, 2);

        // Restart mid-scan of a frame that would otherwise be fatal
        birdy = 10'd475; pipex = {OFF, OFF, OFF};
        frame_tick = 1'b1;
        @(posedge Clk); #1;
        frame_tick = 1'b0;
        @(posedge Clk); #1;
        check_output("abort_busy_pre", busy, 1);
        pulse_restart();
        check_output("abort_busy", busy, 0);
        check_output("abort_lives", lives, 3);
        check_output("abort_pulse", hit_pulse, 0);
        repeat (4) @(posedge Clk);
        #1;
        check_output("abort_pulse_late", hit_pulse, 0);
        check_output("abort_killed", killed, 0);
        check_output("abort_lives_late", lives, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
